iir_decim_out: RTL and testbench

- Output stage placed directly downstream of an iir_2 cascade.
- Consumes the full-width signed sample stream `y` and decimates by 2^LOG2_R using accumulate-and-dump averaging.
- Saturates each average to OUT_WIDTH and buffers it in a small FIFO.
- Presents results on a valid/ready interface to the downstream consumer (DAC packer / capture logic).

---
 rtl/iir_decim_out_pkg.sv | 21 ++
 rtl/iir_decim_out_fifo.sv | 53 +++++
 rtl/iir_decim_out.sv | 87 ++++++++
 tb/tb_iir_decim_out.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/iir_decim_out_pkg.sv
// Helpers shared by the iir_* stages: constant clog2 and a signed saturating clamp.
package iir_decim_out_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Clamp a sign-extended 64-bit value into the range of an ow-bit signed word.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int ow);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/iir_decim_out_fifo.sv
// First-word-fall-through FIFO; the head word is held in a register so it
// stays put when the FIFO drains empty.
module sync_fifo_fwft
  import iir_decim_out_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    level
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]      cnt, cnt_n;
  logic             do_push, do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign level    = cnt;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_ptr_n = do_pop ? rd_ptr + 1'b1 : rd_ptr;
  assign cnt_n    = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_n;
      cnt    <= cnt_n;
      // New head is the incoming word only when it lands in the slot we now point at.
      if (cnt_n != '0)
        dout <= (do_push && rd_ptr_n == wr_ptr) ? din : mem[rd_ptr_n];
    end
  end
endmodule

// File: rtl/iir_decim_out.sv
// Decimating output stage: accumulate-and-dump average of 2^LOG2_R samples,
// saturate to OUT_WIDTH, buffer in a FWFT FIFO behind a valid/ready port.
module iir_decim_out
  import iir_decim_out_pkg::*;
#(
  parameter int BITWIDTH   = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int LOG2_R     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [BITWIDTH-1:0]         x,
  input  logic                               in_valid,
  output logic signed [OUT_WIDTH-1:0]        out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [clog2(FIFO_DEPTH):0]         level,
  output logic                               sat_flag,
  output logic                               ovf_flag,
  input  logic                               clr_flags
);
  localparam int R  = 1 << LOG2_R;
  localparam int AW = BITWIDTH + LOG2_R;
  localparam int CW = (LOG2_R > 0) ? LOG2_R : 1;

  logic signed [AW-1:0] acc, sum, stage;
  logic [CW-1:0]        cnt;
  logic                 stage_valid, last;
  logic signed [63:0]   wide, clamped;
  logic                 clamp, full, empty, ovf_evt;

  assign last = (cnt == CW'(R - 1));
  assign sum  = acc + AW'(x);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      stage       <= '0;
      stage_valid <= 1'b0;
    end else begin
      stage_valid <= 1'b0;
      if (in_valid) begin
        if (last) begin
          acc         <= '0;
          cnt         <= '0;
          stage       <= sum >>> LOG2_R;
          stage_valid <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign wide    = 64'(stage);
  assign clamped = sat_s(wide, OUT_WIDTH);
  assign clamp   = (clamped != wide);
  // A full FIFO still accepts the word if the consumer frees a slot this edge.
  assign ovf_evt = stage_valid && full && !(out_ready && !empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      sat_flag <= (stage_valid && clamp) || (sat_flag && !clr_flags);
      ovf_flag <= ovf_evt || (ovf_flag && !clr_flags);
    end
  end

  sync_fifo_fwft #(.WIDTH(OUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stage_valid),
    .pop   (out_ready),
    .din   (clamped[OUT_WIDTH-1:0]),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid = !empty;
endmodule

// File: tb/tb_iir_decim_out.sv
// Scoreboard bench for iir_decim_out: directed scenarios plus a randomized run
// checked against an arithmetic block-average model.
module tb_iir_decim_out;
  localparam int R     = 4;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] x;
  logic               in_valid;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         level;
  logic               sat_flag, ovf_flag, clr_flags;

  iir_decim_out #(.BITWIDTH(32), .OUT_WIDTH(16), .LOG2_R(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .level(level),
    .sat_flag(sat_flag), .ovf_flag(ovf_flag), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     n_pops = 0;
  longint exp_q[$];
  longint acc_m = 0;
  int     n_m = 0;
  bit     exp_sat = 0, exp_ovf = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: floor of block mean, clamped; dropped when the buffer already holds DEPTH words.
  task automatic model_in(input int xv);
    longint q;
    acc_m += longint'(xv);
    n_m++;
    if (n_m == R) begin
      q = acc_m / R;
      if ((acc_m % R) != 0 && acc_m < 0) q--;
      if (q > 32767) begin q = 32767; exp_sat = 1; end
      else if (q < -32768) begin q = -32768; exp_sat = 1; end
      if (exp_q.size() >= DEPTH) exp_ovf = 1;
      else exp_q.push_back(q);
      acc_m = 0;
      n_m = 0;
    end
  endtask

  task automatic cyc(input int xv, input bit v);
    x = xv;
    in_valid = v;
    if (v) model_in(xv);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(9999, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got %0d expected none", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    int pops0, lowrun, xv;
    rst = 1'b1; x = 0; in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_ovf", ovf_flag, 0);
    rst = 1'b0;
    idle(2);

    // basic average and latency
    cyc(100, 1); cyc(200, 1); cyc(300, 1); cyc(400, 1);
    chk("lat_e0_valid", out_valid, 0);
    idle(1);
    chk("lat_e1_valid", out_valid, 1);
    chk("lat_e1_data", out_data, 250);
    idle(1);
    chk("lat_e2_valid", out_valid, 0);
    chk("lat_e2_level", level, 0);

    // floor toward -inf
    cyc(-1, 1); cyc(-1, 1); cyc(-1, 1); cyc(-2, 1);
    idle(3);
    chk("neg_sat_flag", sat_flag, 0);

    // gapped input, idle x ignored
    for (int i = 1; i <= 4; i++) begin
      cyc(100 * i, 1);
      cyc(9999, 0);
    end
    idle(3);
    chk("gap_drained", exp_q.size(), 0);

    // saturation both ways
    repeat (4) cyc(100000, 1);
    repeat (4) cyc(-100000, 1);
    idle(3);
    chk("sat_flag_set", sat_flag, exp_sat);
    clr_flags = 1'b1;
    idle(1);
    clr_flags = 1'b0;
    exp_sat = 0;
    chk("sat_flag_clr", sat_flag, 0);

    // overflow with consumer stalled
    out_ready = 1'b0;
    repeat (16) cyc(8, 1);
    idle(2);
    chk("ovf_level4", level, 4);
    chk("ovf_not_yet", ovf_flag, 0);
    repeat (4) cyc(8, 1);
    idle(2);
    chk("ovf_level_held", level, 4);
    chk("ovf_flag", ovf_flag, exp_ovf);
    chk("ovf_hold_valid", out_valid, 1);
    chk("ovf_hold_data", out_data, 8);
    pops0 = n_pops;
    out_ready = 1'b1;
    idle(8);
    chk("ovf_drain_count", n_pops - pops0, 4);
    chk("ovf_drain_valid", out_valid, 0);
    chk("ovf_drain_q", exp_q.size(), 0);

    // reset mid-block
    cyc(1000, 1); cyc(1000, 1);
    rst = 1'b1;
    idle(1);
    acc_m = 0; n_m = 0; exp_sat = 0; exp_ovf = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_sat", sat_flag, 0);
    chk("mid_rst_ovf", ovf_flag, 0);
    rst = 1'b0;
    pops0 = n_pops;
    repeat (4) cyc(4, 1);
    idle(3);
    chk("mid_rst_words", n_pops - pops0, 1);

    // randomized run, consumer never stalls more than 3 cycles
    lowrun = 0;
    for (int i = 0; i < 800; i++) begin
      if (lowrun < 3 && $urandom_range(0, 3) == 0) begin
        out_ready = 1'b0; lowrun++;
      end else begin
        out_ready = 1'b1; lowrun = 0;
      end
      if ($urandom_range(0, 3) == 0) xv = int'($urandom);
      else xv = int'($urandom_range(0, 80000)) - 40000;
      cyc(xv, 1'($urandom_range(0, 1)));
    end
    out_ready = 1'b1;
    idle(10);
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_level", level, 0);
    chk("rnd_sat", sat_flag, exp_sat);
    chk("rnd_ovf", ovf_flag, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
